// File: rtl/multdiv.sv
// multdiv: iterative signed 32-bit multiply/divide unit; define MULTDIV_BOOTH_EN for radix-4 Booth multiply
module multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`ifdef MULTDIV_BOOTH_EN
  localparam logic [5:0] MUL_TC = 6'd16;
  localparam int MUL_SH = 2;
`else
  localparam logic [5:0] MUL_TC = 6'd32;
  localparam int MUL_SH = 1;
`endif
  state_t      state_q, state_d;
  logic [63:0] a_q, a_d, acc_q, acc_d;
  logic [32:0] b_q, b_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d, ovf_q, ovf_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
  logic [31:0] abs_a, abs_b, quo;
  logic [63:0] prod, sh, addend, mul_a0;
  logic [32:0] diff, hi, mul_b0;
  assign abs_a = data_operandA[31] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[31] ? -data_operandB : data_operandB;
  assign sh    = {acc_q[62:0], 1'b0};
  assign diff  = {1'b0, sh[63:32]} - {1'b0, b_q[31:0]};
  assign quo   = neg_q ? -acc_q[31:0] : acc_q[31:0];
  assign hi    = prod[63:31];
`ifdef MULTDIV_BOOTH_EN
  // Booth digit from the current bit triple scales the sign-extended multiplicand
  assign addend = b_q[2:0] == 3'b011 ? a_q << 1 :
                  b_q[2:0] == 3'b100 ? -(a_q << 1) :
                  (b_q[1] ^ b_q[0]) ? (b_q[2] ? -a_q : a_q) : 64'd0;
  assign prod   = acc_q;
  assign mul_a0 = {{32{data_operandA[31]}}, data_operandA};
  assign mul_b0 = {data_operandB, 1'b0};
`else
  // Shift-add on magnitudes; the sign is applied once the product is complete
  assign addend = b_q[0] ? a_q : 64'd0;
  assign prod   = neg_q ? -acc_q : acc_q;
  assign mul_a0 = {32'd0, abs_a};
  assign mul_b0 = {1'b0, abs_b};
`endif
  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
  // Next-state: a start pulse always wins and aborts any op in flight
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    if (ctrl_MULT || ctrl_DIV) begin
      state_d = ctrl_MULT ? MUL : DIV;
      a_d     = ctrl_MULT ? mul_a0 : 64'd0;
      b_d     = ctrl_MULT ? mul_b0 : {1'b0, abs_b};
      acc_d   = ctrl_MULT ? 64'd0 : {32'd0, abs_a};
      cnt_d   = 6'd0;
      neg_d   = data_operandA[31] ^ data_operandB[31];
      ovf_d   = !ctrl_MULT && data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        MUL: begin
          if (cnt_q == MUL_TC) begin
            state_d = DONE;
            res_d   = prod[31:0];
            exc_d   = (|hi) && !(&hi);
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            acc_d = acc_q + addend;
            a_d   = a_q << MUL_SH;
            b_d   = b_q >> MUL_SH;
            cnt_d = cnt_q + 6'd1;
          end
        end
        DIV: begin
          if (b_q[31:0] == 32'd0 || cnt_q == 6'd32) begin
            state_d = DONE;
            res_d   = b_q[31:0] == 32'd0 ? 32'd0 : quo;
            exc_d   = b_q[31:0] == 32'd0 || ovf_q;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            acc_d = diff[32] ? sh : {diff[31:0], sh[31:1], 1'b1};
            cnt_d = cnt_q + 6'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed vector bench for multdiv
module tb_multdiv;
`ifdef MULTDIV_BOOTH_EN
  localparam int ML = 17;
`else
  localparam int ML = 33;
`endif
  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] opa = '0, opb = '0;
  logic        mult = 1'b0, div = 1'b0;
  logic [31:0] res;
  logic        exc, rdy, busy;
  int          n_chk = 0, n_fail = 0;

  multdiv dut (
    .clock(clock), .reset(reset), .data_operandA(opa), .data_operandB(opb),
    .ctrl_MULT(mult), .ctrl_DIV(div), .data_result(res), .data_exception(exc),
    .data_resultRDY(rdy), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        m;
    logic [31:0] a, b, r;
    logic        e;
    int          lat;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic e, input int lat, input string nm);
    int n;
    @(negedge clock);
    opa = a; opb = b; mult = m; div = d;
    @(negedge clock);
    mult = 1'b0; div = 1'b0; opa = $urandom; opb = $urandom;
    chk({nm, " busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " result"}, res, r);
    chk({nm, " exception"}, {31'd0, exc}, {31'd0, e});
    @(negedge clock);
    chk({nm, " strobe width"}, {31'd0, rdy}, 32'd0);
  endtask

  initial begin
    vec_t vt[12];
    int   strobes, first;
    vt[0]  = '{1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, ML, "mul 7*-3"};
    vt[1]  = '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, ML, "mul ovf"};
    vt[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33, "div -7/2"};
    vt[3]  = '{1'b0, 32'd5,          32'd0,         32'h0000_0000, 1'b1, 1,  "div by 0"};
    vt[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, "div min/-1"};
    vt[5]  = '{1'b1, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 32'd30,        1'b0, ML, "mul -5*-6"};
    vt[6]  = '{1'b1, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, ML, "mul max*2"};
    vt[7]  = '{1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, ML, "mul min*1"};
    vt[8]  = '{1'b1, 32'h4000_0000,  32'hFFFF_FFFE, 32'h8000_0000, 1'b0, ML, "mul 2^30*-2"};
    vt[9]  = '{1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0, 33, "div -100/-7"};
    vt[10] = '{1'b0, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33, "div 7/-2"};
    vt[11] = '{1'b0, 32'd0,          32'd5,         32'd0,         1'b0, 33, "div 0/5"};
    repeat (3) @(negedge clock);
    chk("reset result", res, 32'd0);
    chk("reset rdy/exc/busy", {29'd0, rdy, exc, busy}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++)
      run_op(vt[i].m, !vt[i].m, vt[i].a, vt[i].b, vt[i].r, vt[i].e, vt[i].lat, vt[i].nm);
    // abort: a DIV 10 cycles into a MULT replaces it, with exactly one strobe
    @(negedge clock);
    opa = 32'd6; opb = 32'd6; mult = 1'b1;
    @(negedge clock);
    mult = 1'b0;
    strobes = 0;
    first = -1;
    repeat (9) begin
      @(negedge clock);
      if (rdy) strobes++;
    end
    opa = 32'd100; opb = 32'd10; div = 1'b1;
    @(negedge clock);
    div = 1'b0; opa = 32'd0; opb = 32'd0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (rdy) begin
        strobes++;
        if (first < 0) first = k;
        chk("abort result", res, 32'd10);
      end
    end
    chk("abort strobe count", strobes, 32'd1);
    chk("abort latency", first, 32'd33);
    // reset mid-divide: idle with reset values, no strobe afterwards
    @(negedge clock);
    opa = 32'd100; opb = 32'd3; div = 1'b1;
    @(negedge clock);
    div = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("reset mid-div busy", {31'd0, busy}, 32'd0);
    chk("reset mid-div result", res, 32'd0);
    strobes = 0;
    repeat (40) begin
      @(negedge clock);
      if (rdy) strobes++;
    end
    chk("reset mid-div strobes", strobes, 32'd0);
    // simultaneous start: multiply wins
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 32'd12, 1'b0, ML, "mul+div 3*4");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
